serial_in_parallel_out_shift_reg: RTL and testbench
===================================================

// Module: serial_in_parallel_out_shift_reg
// PURPOSE
//  Receive-side counterpart of the parallel-in/serial-out shift register.
//  - Collects a qualified serial bit stream, LSB first, into DATA_WIDTH-bit words.
//  - Presents each word on a registered valid/ready output stage, so shifting continues while a word waits.
//  - Flags words lost to back-pressure; a sync pulse realigns word boundaries.
// PARAMETERS
//  DATA_WIDTH  16  word width in bits; must be >= 2 (elaboration-time check)
// PORTS
//  clk         in   1           single clock, all state on posedge
//  reset       in   1           synchronous, active-high reset
//  din         in   1           serial data bit
//  din_en      in   1           din is valid this cycle (one bit per qualified cycle)
//  sync        in   1           word-boundary realign: discard partial word
//  dout        out  DATA_WIDTH  assembled word; bit 0 = first bit received
//  dout_valid  out  1           dout holds an unconsumed word
//  dout_ready  in   1           consumer accepts dout this cycle
//  overflow    out  1           sticky: a completed word was dropped
//  ovf_clr     in   1           clears overflow
//  bit_cnt     out  $clog2(DATA_WIDTH)  bits collected into current partial word
// BEHAVIOUR
//  Reset (reset=1 at posedge)
//   - shift_q=0, bit_cnt=0, dout=0, dout_valid=0, overflow=0.
//   - Reset overrides every other input; a partial word is lost.
//  Shift
//   - din_en=1: shift_q <= {din, shift_q[DATA_WIDTH-1:1]}; bit_cnt increments.
//   - din_en=0: shift_q and bit_cnt hold.
//  Completion
//   - din_en=1 with bit_cnt==DATA_WIDTH-1 completes a word: word = {din, shift_q[DATA_WIDTH-1:1]}.
//   - bit_cnt wraps to 0 on completion.
//  Sync
//   - sync=1, din_en=0: bit_cnt <= 0.
//   - sync=1, din_en=1: din becomes bit 0 of a new word, bit_cnt <= 1.
//   - sync never completes a word, never touches the output stage.
//  Output stage (one-entry register)
//   - Transfer occurs when dout_valid && dout_ready.
//   - Completion with stage empty or transferring: dout <= word, dout_valid=1 from the next cycle.
//     Latency: valid the cycle after the edge sampling the last bit.
//   - Transfer without completion: dout_valid <= 0; dout holds its last value.
//   - Completion while dout_valid=1 and dout_ready=0: word dropped, dout unchanged, overflow <= 1.
//   - dout and dout_valid are stable while dout_valid && !dout_ready.
//  Overflow
//   - ovf_clr=1 clears it. If ovf_clr and a new drop occur in the same cycle, overflow stays 1 (set wins).
//  Compatibility
//   - Back-to-back words with no idle cycles are supported.
//   - Bit order matches the PISO: its dout stream reassembles to the original din.
// STRUCTURE
//  Shared package sipo_pkg
//   - function cnt_w(width) = $clog2(width).
//   - localparam type for the output word (logic [DATA_WIDTH-1:0]).
//  Sub-module sipo_out_stage
//   - One-entry valid/ready holding register with drop/overflow logic.
//   - Top holds the shift register, bit counter and sync handling.
// TESTING
//  1. din=LSB-first 16'hA5C3 on 16 consecutive din_en, dout_ready=1 -> dout=16'hA5C3, dout_valid high exactly 1 cycle.
//  2. Loopback PISO->SIPO with din_en gaps (random idle cycles), words 16'h0001, 16'h8000, 16'hFFFF -> identical words, in order.
//  3. Hold dout_ready=0, send 16'h1234 then 16'h5678 -> dout stays 16'h1234, overflow=1.
//     Then ready=1 -> 16'h1234 taken; ovf_clr -> overflow=0.
//  4. 5 bits, then sync with din_en=1, din=1, then 15 bits of 16'hFFFF pattern -> dout=16'hFFFF, bit_cnt=1 after sync.
//  5. reset at bit 9 of a word -> all outputs 0 next cycle.
//     Following full 16-bit word 16'h00FF -> dout=16'h00FF, no overflow.
//  6. Completion in same cycle as transfer (ready=1, back-to-back words 16'hAAAA, 16'h5555) -> dout_valid stays 1, no overflow.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared helpers for the serial-in/parallel-out receiver.
package sipo_pkg;

  localparam int DEFAULT_WIDTH = 16;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_out_stage.sv
// One-entry valid/ready output register; records words dropped while full and stalled.
module sipo_out_stage #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  ready,
  input  logic                  ovf_clr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  overflow
);

  logic transfer, accept, drop;

  assign transfer = dout_valid && ready;
  assign accept   = load && (!dout_valid || ready);
  assign drop     = load && dout_valid && !ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (accept) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else if (transfer) begin
        dout_valid <= 1'b0;
      end
      // A new drop outranks a simultaneous clear.
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_in_parallel_out_shift_reg.sv
// LSB-first serial collector: shift register, bit counter and sync realign feeding a registered output stage.
module serial_in_parallel_out_shift_reg
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         din,
  input  logic                         din_en,
  input  logic                         sync,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic                         overflow,
  input  logic                         ovf_clr,
  output logic [cnt_w(DATA_WIDTH)-1:0] bit_cnt
);

  localparam int CW = cnt_w(DATA_WIDTH);
  localparam type word_t = logic [DATA_WIDTH-1:0];
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  if (DATA_WIDTH < 2) begin : g_width_check
    $error("DATA_WIDTH must be >= 2");
  end

  word_t shift_q, word;
  logic  complete;

  assign word     = {din, shift_q[DATA_WIDTH-1:1]};
  assign complete = din_en && !sync && (bit_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (din_en) begin
      shift_q <= word;
      // With sync, this bit starts a fresh word; earlier bits shift out before completion.
      if (sync)          bit_cnt <= CW'(1);
      else if (complete) bit_cnt <= '0;
      else               bit_cnt <= bit_cnt + 1'b1;
    end else if (sync) begin
      bit_cnt <= '0;
    end
  end

  sipo_out_stage #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clk        (clk),
    .reset      (reset),
    .load       (complete),
    .word       (word),
    .ready      (dout_ready),
    .ovf_clr    (ovf_clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .overflow   (overflow)
  );

endmodule

// File: tb/tb_serial_in_parallel_out_shift_reg.sv
// Scoreboarded directed bench: stimulus pushes expected words, a negedge monitor pops on each transfer.
module tb_serial_in_parallel_out_shift_reg;

  localparam int W  = 16;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          reset, din, din_en, sync, dout_ready, ovf_clr;
  logic [W-1:0]  dout;
  logic          dout_valid, overflow;
  logic [CW-1:0] bit_cnt;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  serial_in_parallel_out_shift_reg #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_en     (din_en),
    .sync       (sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .bit_cnt    (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input logic s);
    din = b; din_en = 1'b1; sync = s;
    tick();
    din_en = 1'b0; sync = 1'b0;
  endtask

  // Reference PISO: serialise LSB first, optionally with random idle gaps.
  task automatic send_word(input logic [W-1:0] w, input bit gaps);
    logic [W-1:0] v;
    v = w;
    for (int i = 0; i < W; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      drive_bit(v[i], 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {16'h0, dout}, 32'hDEAD_BEEF);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("word", {16'h0, dout}, {16'h0, e});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    reset = 1'b1; din = 1'b0; din_en = 1'b0; sync = 1'b0;
    dout_ready = 1'b1; ovf_clr = 1'b0;
    tick(); tick();
    chk("rst_dout", {16'h0, dout}, 32'h0);
    chk("rst_valid", {31'h0, dout_valid}, 32'h0);
    chk("rst_ovf", {31'h0, overflow}, 32'h0);
    chk("rst_bitcnt", {28'h0, bit_cnt}, 32'h0);
    reset = 1'b0;
    tick();

    // 1: single word, valid for exactly one cycle
    exp_q.push_back(16'hA5C3);
    send_word(16'hA5C3, 1'b0);
    chk("t1_valid", {31'h0, dout_valid}, 32'h1);
    chk("t1_bitcnt", {28'h0, bit_cnt}, 32'h0);
    tick();
    chk("t1_valid_drop", {31'h0, dout_valid}, 32'h0);
    chk("t1_dout_hold", {16'h0, dout}, 32'h0000_A5C3);

    // 2: loopback with idle gaps
    exp_q.push_back(16'h0001); send_word(16'h0001, 1'b1);
    exp_q.push_back(16'h8000); send_word(16'h8000, 1'b1);
    exp_q.push_back(16'hFFFF); send_word(16'hFFFF, 1'b1);
    tick(); tick();
    chk("t2_ovf", {31'h0, overflow}, 32'h0);

    // 3: back-pressure drop, then drain and clear
    dout_ready = 1'b0;
    exp_q.push_back(16'h1234);
    send_word(16'h1234, 1'b0);
    send_word(16'h5678, 1'b0);
    tick();
    chk("t3_dout", {16'h0, dout}, 32'h0000_1234);
    chk("t3_valid", {31'h0, dout_valid}, 32'h1);
    chk("t3_ovf", {31'h0, overflow}, 32'h1);
    dout_ready = 1'b1;
    tick();
    chk("t3_valid_after", {31'h0, dout_valid}, 32'h0);
    chk("t3_ovf_sticky", {31'h0, overflow}, 32'h1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("t3_ovf_clr", {31'h0, overflow}, 32'h0);

    // 4: sync realign mid-word
    v = 16'b10110;
    for (int i = 0; i < 5; i++) drive_bit(v[i], 1'b0);
    chk("t4_bitcnt5", {28'h0, bit_cnt}, 32'd5);
    exp_q.push_back(16'hFFFF);
    drive_bit(1'b1, 1'b1);
    chk("t4_bitcnt_sync", {28'h0, bit_cnt}, 32'd1);
    chk("t4_no_word", {31'h0, dout_valid}, 32'h0);
    for (int i = 0; i < W - 1; i++) drive_bit(1'b1, 1'b0);
    chk("t4_dout", {16'h0, dout}, 32'h0000_FFFF);
    tick();

    // 5: reset in the middle of a word
    v = 16'h3C3C;
    for (int i = 0; i < 9; i++) drive_bit(v[i], 1'b0);
    reset = 1'b1; din = 1'b1; din_en = 1'b1;
    tick();
    reset = 1'b0; din_en = 1'b0;
    chk("t5_dout", {16'h0, dout}, 32'h0);
    chk("t5_valid", {31'h0, dout_valid}, 32'h0);
    chk("t5_ovf", {31'h0, overflow}, 32'h0);
    chk("t5_bitcnt", {28'h0, bit_cnt}, 32'h0);
    exp_q.push_back(16'h00FF);
    send_word(16'h00FF, 1'b0);
    chk("t5_dout2", {16'h0, dout}, 32'h0000_00FF);
    tick();
    chk("t5_ovf2", {31'h0, overflow}, 32'h0);

    // 6: completion coincides with transfer of the held word
    dout_ready = 1'b0;
    exp_q.push_back(16'hAAAA);
    exp_q.push_back(16'h5555);
    send_word(16'hAAAA, 1'b0);
    v = 16'h5555;
    for (int i = 0; i < W - 1; i++) drive_bit(v[i], 1'b0);
    dout_ready = 1'b1;
    drive_bit(v[W-1], 1'b0);
    chk("t6_valid", {31'h0, dout_valid}, 32'h1);
    chk("t6_dout", {16'h0, dout}, 32'h0000_5555);
    chk("t6_ovf", {31'h0, overflow}, 32'h0);
    tick(); tick();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
